// File: rtl/radix_mul_arbiter.sv
// radix_mul_arbiter: round-robin sequencer sharing one multiplier core among N_REQ requesters, with a hang watchdog
module radix_mul_arbiter #(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT        = 31,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_x,
  input  logic [N_REQ*WIDTH-1:0]   req_y,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic [2*WIDTH-1:0]       result,
  output logic                     busy,
  output logic [WIDTH-1:0]         mul_x,
  output logic [WIDTH-1:0]         mul_y,
  output logic                     mul_start,
  output logic                     mul_reset,
  input  logic [2*WIDTH-1:0]       mul_result,
  input  logic                     mul_ready
);
  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int RW = $clog2(RECOVER_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} state_t;
  state_t             state_q, state_d;
  logic [GW-1:0]      g_q, g_d, last_q, last_d, pick;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RW-1:0]      rec_q, rec_d;
  logic               ready_q, busy_q, busy_d, start_q, start_d;
  logic [N_REQ-1:0]   ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  // Walk downward so the nearest requester after last_q is the one left standing.
  always_comb begin
    pick = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(last_q) + k) % N_REQ]) pick = GW'((int'(last_q) + k) % N_REQ);
  end
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    last_d   = last_q;
    timer_d  = timer_q;
    rec_d    = rec_q;
    ack_d    = '0;
    done_d   = '0;
    err_d    = '0;
    start_d  = 1'b0;
    result_d = result_q;
    x_d      = x_q;
    y_d      = y_q;
    case (state_q)
      IDLE: if (|req) begin
        g_d     = pick;
        x_d     = req_x[int'(pick)*WIDTH +: WIDTH];
        y_d     = req_y[int'(pick)*WIDTH +: WIDTH];
        ack_d   = N_REQ'(1) << pick;
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (mul_ready && !ready_q) begin
        result_d = mul_result;
        done_d   = N_REQ'(1) << g_q;
        last_d   = g_q;
        state_d  = IDLE;
      end else if (timer_q == TW'(TIMEOUT)) begin
        err_d   = N_REQ'(1) << g_q;
        last_d  = g_q;
        rec_d   = '0;
        state_d = RECOVER;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      RECOVER: if (rec_q == RW'(RECOVER_CYCLES - 1)) state_d = IDLE;
               else rec_d = rec_q + 1'b1;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      g_q      <= '0;
      last_q   <= GW'(N_REQ - 1);
      timer_q  <= '0;
      rec_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      result_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      rec_q    <= rec_d;
      ready_q  <= mul_ready;
      busy_q   <= busy_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end
  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign mul_start = start_q;
  assign mul_reset = reset | (state_q == RECOVER);
endmodule
